// File: rtl/expr_pipe_eval_if.sv
// Handshake bundle for expr_pipe_eval: operand beat in, result beat out, consumed-beat counter.
interface expr_pipe_eval_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2,
    parameter int CNT_W = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic [NCH*WIDTH-1:0]        in_a;
    logic [NCH*WIDTH-1:0]        in_b;
    logic [NCH*3-1:0]            in_op;
    logic [NCH-1:0]              in_sgn;
    logic                        out_valid;
    logic                        out_ready;
    logic [NCH*(WIDTH+1)-1:0]    out_y;
    logic [CNT_W-1:0]            txn_count;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_sgn, out_ready,
        output in_ready, out_valid, out_y, txn_count
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_sgn, out_ready,
        input  in_ready, out_valid, out_y, txn_count
    );
endinterface

// File: rtl/expr_pipe_eval.sv
// Two-stage pipelined per-lane expression evaluator with Verilog width/sign semantics.
// S1 holds extended operands, S2 holds the result; both stall together under backpressure.
module expr_pipe_eval #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    expr_pipe_eval_if.slave  bus
);
    localparam int OUT_W = WIDTH + 1;

    logic [NCH-1:0][OUT_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [NCH-1:0][WIDTH-1:0] s1_b_q, s1_b_d;
    logic [NCH-1:0][2:0]       s1_op_q, s1_op_d;
    logic [NCH-1:0]            s1_sgn_q, s1_sgn_d;
    logic                      s1_valid_q, s1_valid_d;
    logic                      s2_valid_q, s2_valid_d;
    logic [NCH*OUT_W-1:0]      y_q, y_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      advance;
    logic                      accept;

    function automatic logic [OUT_W-1:0] eval(
        input logic [2:0]       op,
        input logic             sgn,
        input logic [OUT_W-1:0] x,
        input logic [OUT_W-1:0] y,
        input logic [WIDTH-1:0] b
    );
        logic [OUT_W-1:0] r;
        r = '0;
        case (op)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd2: r = x & y;
            3'd3: r = x ^ y;
            3'd4: r = x << b;
            // Kept as separate statements so the signed branch stays arithmetic.
            3'd5: if (sgn) r = $signed(x) >>> b; else r = x >> b;
            3'd6: if (sgn) r = {{(OUT_W-1){1'b0}}, $signed(x) < $signed(y)};
                  else     r = {{(OUT_W-1){1'b0}}, x < y};
            3'd7: r = {{(OUT_W-1){1'b0}}, x == y};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign advance       = !s2_valid_q || bus.out_ready;
    assign bus.in_ready  = !s1_valid_q || advance;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_y     = y_q;
    assign bus.txn_count = cnt_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_sgn_d   = s1_sgn_q;
        s2_valid_d = s2_valid_q;
        y_d        = y_q;

        if (bus.in_ready) s1_valid_d = bus.in_valid;
        if (accept) begin
            for (int i = 0; i < NCH; i++) begin
                s1_x_d[i]   = {bus.in_sgn[i] & bus.in_a[i*WIDTH + WIDTH-1], bus.in_a[i*WIDTH +: WIDTH]};
                s1_y_d[i]   = {bus.in_sgn[i] & bus.in_b[i*WIDTH + WIDTH-1], bus.in_b[i*WIDTH +: WIDTH]};
                s1_b_d[i]   = bus.in_b[i*WIDTH +: WIDTH];
                s1_op_d[i]  = bus.in_op[i*3 +: 3];
                s1_sgn_d[i] = bus.in_sgn[i];
            end
        end

        // A bubble moving into S2 clears out_valid but leaves out_y at its last value.
        if (advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                for (int i = 0; i < NCH; i++) begin
                    y_d[i*OUT_W +: OUT_W] = eval(s1_op_q[i], s1_sgn_q[i], s1_x_q[i], s1_y_q[i], s1_b_q[i]);
                end
            end
        end

        cnt_d = cnt_q + CNT_W'(s2_valid_q && bus.out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_sgn_q   <= '0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s1_sgn_q   <= s1_sgn_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule
